fetch_unit: RTL
===============

// Module: fetch_unit
// PURPOSE
//  Instruction fetch stage directly upstream of the decode/control stage.
//  Holds the PC and issues single-outstanding requests to instruction memory.
//  Presents the fetched word as o_instrCode with a valid/stall handshake.
//  Applies PC redirects from branch and jump outcomes when an instruction is consumed.
// PARAMETERS
//  RESET_PC  32'h0000_0000  PC value loaded on reset; bits [1:0] must be 00
// PORTS
//  i_clk           in   1   clock; all state updates on the rising edge
//  i_rst_n         in   1   asynchronous reset, active-low
//  i_stall         in   1   downstream hold; 0 in a cycle with o_valid=1 consumes the instruction
//  i_branch        in   1   branch taken, qualified by consumption
//  i_branchOffset  in   32  sign-extended immediate in words
//  i_jump          in   1   jump taken, qualified by consumption; has priority over i_branch
//  i_jumpIndex     in   26  jump target index
//  o_imemReq       out  1   instruction memory request
//  o_imemAddr      out  32  request address, equal to the PC
//  i_imemAck       in   1   memory response valid; data is on i_imemData in the same cycle
//  i_imemData      in   32  instruction word
//  o_instrCode     out  32  instruction presented to decode
//  o_pc            out  32  address of o_instrCode
//  o_pcPlus4       out  32  o_pc + 4
//  o_valid         out  1   o_instrCode is valid
// BEHAVIOUR
//  Reset values:
//  - pc = RESET_PC
//  - o_instrCode = 0, o_valid = 0, o_imemReq = 0
//  - o_imemAddr = RESET_PC, o_pc = RESET_PC, o_pcPlus4 = RESET_PC + 4
//  - state = IDLE
//  FSM states: IDLE, REQ, HOLD.
//  - IDLE: entered only by reset. Moves to REQ on the first clock edge after reset is released.
//  - REQ: o_imemReq = 1 and o_imemAddr = pc. Wait states are unbounded.
//    On i_imemAck = 1, register i_imemData into o_instrCode, set o_valid = 1, and go to HOLD.
//  - HOLD: o_valid = 1 and o_imemReq = 0. o_instrCode, o_pc and o_pcPlus4 are stable while i_stall = 1.
//    Consumption is o_valid & !i_stall. On consumption: o_valid <= 0, pc <= next_pc, go to REQ.
//  next_pc, all arithmetic modulo 2^32:
//  - if i_jump: {pc4[31:28], i_jumpIndex, 2'b00}
//  - else if i_branch: pc4 + (i_branchOffset << 2)
//  - otherwise: pc4, where pc4 = pc + 4
//  Latency and throughput:
//  - ack to o_valid is 1 cycle.
//  - Best case with ack in the first REQ cycle: one instruction every 2 cycles.
//  Boundary conditions:
//  - i_branch, i_jump and their operands are ignored unless consumption occurs in that cycle.
//  - i_imemAck is ignored in IDLE and HOLD.
//  - PC wrap: 32'hFFFF_FFFC + 4 gives 32'h0000_0000, with no error flag.
//  - Branch offset arithmetic wraps silently in both directions.
//  - Reset asserted mid-REQ: the request drops immediately and the FSM returns to IDLE.
//    A stale ack after reset release is ignored, because IDLE does not accept acks.
//  - i_jump and i_branch both 1: the jump wins.
// CONFIGURATION
//  FETCH_PERF_CNT_EN
//  - Defined: adds port o_fetchCount (out, 32), reset to 0.
//    It increments by 1 on every consumption, wraps from 2^32-1 to 0, and is unaffected by i_stall.
//  - Undefined: the port and the counter are absent; all other behaviour is identical.
// TESTING
//  1. Reset release with RESET_PC = 0 and ack in the first REQ cycle:
//     o_imemAddr = 0, 4, 8 on successive requests; o_valid pulses every 2 cycles with no stall.
//  2. In HOLD at pc = 0x100, hold i_stall = 1 for 5 cycles:
//     o_instrCode and o_pc are stable, o_imemReq = 0, and no PC advance.
//  3. Consume at pc = 0x100 with i_branch = 1 and offset = 0xFFFF_FFFE:
//     next o_imemAddr = 0x0FC. With offset = 3: next o_imemAddr = 0x110.
//  4. At pc = 0x1000_0040, i_jump = 1 and i_jumpIndex = 26'h000_0010, with i_branch = 1 at the same time:
//     next o_imemAddr = 0x1000_0040, i.e. the jump wins.
//  5. At pc = 0xFFFF_FFFC, consume with no redirect:
//     next o_imemAddr = 0x0000_0000.
//  6. Assert i_rst_n = 0 during a REQ wait state, then ack 1 cycle after release:
//     o_valid stays 0 and the first request goes to RESET_PC.
//     With FETCH_PERF_CNT_EN defined, o_fetchCount = 0 after reset and 3 after 3 consumptions.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one outstanding imem request at a time,
// and hands the fetched word to decode. Optional consumption counter: FETCH_PERF_CNT_EN.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_stall,
  input  logic        i_branch,
  input  logic [31:0] i_branchOffset,
  input  logic        i_jump,
  input  logic [25:0] i_jumpIndex,
  output logic        o_imemReq,
  output logic [31:0] o_imemAddr,
  input  logic        i_imemAck,
  input  logic [31:0] i_imemData,
  output logic [31:0] o_instrCode,
  output logic [31:0] o_pc,
  output logic [31:0] o_pcPlus4,
  output logic        o_valid
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] o_fetchCount
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic [31:0] w_pc4;
  logic [31:0] w_offset_bytes;
  logic [31:0] w_next_pc;
  logic        w_capture;
  logic        w_consume;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_capture    = 1'b0;
    w_consume    = 1'b0;
    o_imemReq    = 1'b0;
    o_valid      = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_state_next = S_REQ;
      end
      S_REQ: begin
        o_imemReq = 1'b1;
        if (i_imemAck) begin
          w_capture    = 1'b1;
          w_state_next = S_HOLD;
        end
      end
      S_HOLD: begin
        o_valid = 1'b1;
        if (!i_stall) begin
          w_consume    = 1'b1;
          w_state_next = S_REQ;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Redirect target; jump takes priority over branch, everything wraps mod 2^32.
  assign w_pc4          = r_pc + 32'd4;
  assign w_offset_bytes = i_branchOffset << 2;

  always_comb begin
    w_next_pc = w_pc4;
    if (i_jump) begin
      w_next_pc = {w_pc4[31:28], i_jumpIndex, 2'b00};
    end else if (i_branch) begin
      w_next_pc = w_pc4 + w_offset_bytes;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pc    <= RESET_PC;
      r_instr <= 32'd0;
    end else begin
      if (w_capture) begin
        r_instr <= i_imemData;
      end
      if (w_consume) begin
        r_pc <= w_next_pc;
      end
    end
  end

  assign o_imemAddr  = r_pc;
  assign o_pc        = r_pc;
  assign o_pcPlus4   = w_pc4;
  assign o_instrCode = r_instr;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] r_fetch_count;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_fetch_count <= 32'd0;
    end else if (w_consume) begin
      r_fetch_count <= r_fetch_count + 32'd1;
    end
  end

  assign o_fetchCount = r_fetch_count;
`endif

endmodule
